clk_div_sched: RTL and testbench

Controller that sequences the PHY clock divider and gates access to changes in its rate.
- Generates the divided-clock toggle and a one-cycle slow-domain enable strobe from CLK.
- Runs a lock sequence after reset and after every rate change.
- Accepts divide-ratio change requests over a valid/ready handshake and applies them only on a period boundary, so downstream serialisers never see a runt period.

---
 rtl/clk_sched_pkg.sv | 14 +
 rtl/div_counter.sv | 55 +++++
 rtl/clk_div_sched.sv | 113 +++++++++++
 tb/tb_clk_div_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and constants for the PHY clock divider scheduler
package clk_sched_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int RATIO_MIN = 2;

  typedef enum logic [1:0] {
    LOCK   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } state_e;

endpackage

// File: rtl/div_counter.sv
// rtl/div_counter.sv - period counter producing the slow-domain strobe and divided clock
module div_counter
  import clk_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] ratio_i,
  output logic             terminal_o,
  output logic             en_slow_o,
  output logic             clk_slow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;

  always_comb begin
    terminal_o = !hold_i && !load_i && (cnt_q == ratio_i);
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    clk_d      = clk_q;
    // A load restarts the period without a strobe; clk_slow keeps its phase.
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (!hold_i) begin
      if (terminal_o) begin
        cnt_d = CNT_W'(1);
        en_d  = 1'b1;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CNT_W'(1);
      en_q  <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      clk_q <= clk_d;
    end
  end

  assign en_slow_o  = en_q;
  assign clk_slow_o = clk_q;

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - lock sequencing and boundary-aligned ratio changes for the PHY clock divider
module clk_div_sched
  import clk_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 5,
  parameter int LOCK_CYC = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             hold,
  input  logic             div_req_valid,
  input  logic [CNT_W-1:0] div_req_ratio,
  output logic             div_req_ready,
  output logic             en_slow,
  output logic             clk_slow,
  output logic             locked,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             err_bad_ratio
);

  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  state_e           state_q, state_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             terminal;
  logic             accept;

  div_counter #(.CNT_W(CNT_W)) u_div (
    .clk_i      (CLK),
    .rst_i      (reset),
    .hold_i     (hold),
    .load_i     ((state_q == SWITCH) && !hold),
    .ratio_i    (ratio_q),
    .terminal_o (terminal),
    .en_slow_o  (en_slow),
    .clk_slow_o (clk_slow)
  );

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    ratio_d       = ratio_q;
    pend_d        = pend_q;
    err_d         = 1'b0;
    div_req_ready = (state_q == RUN) && !hold;
    accept        = div_req_valid && div_req_ready;
    if (!hold) begin
      unique case (state_q)
        LOCK: begin
          if (terminal) begin
            if (lock_cnt_q == LW'(LOCK_CYC - 1)) begin
              state_d    = RUN;
              locked_d   = 1'b1;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          // Re-requesting the active ratio is harmless and must not force a relock.
          if (accept) begin
            if (div_req_ratio < CNT_W'(RATIO_MIN)) begin
              err_d = 1'b1;
            end else if (div_req_ratio != ratio_q) begin
              pend_d   = div_req_ratio;
              locked_d = 1'b0;
              state_d  = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (terminal) state_d = SWITCH;
        end
        SWITCH: begin
          ratio_d    = pend_q;
          lock_cnt_d = '0;
          state_d    = LOCK;
        end
        default: state_d = LOCK;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= LOCK;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      ratio_q    <= CNT_W'(DEF_DIV);
      pend_q     <= CNT_W'(DEF_DIV);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      ratio_q    <= ratio_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign locked        = locked_q;
  assign cur_ratio     = ratio_q;
  assign err_bad_ratio = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - scoreboard bench for clk_div_sched
module tb_clk_div_sched;

  localparam int K_EN = 0, K_ERR = 1, K_LOCK = 2, K_RDY = 3, K_RATIO = 4;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic       div_req_valid = 1'b0;
  logic [3:0] div_req_ratio = 4'd0;
  logic       div_req_ready, en_slow, clk_slow, locked, err_bad_ratio;
  logic [3:0] cur_ratio;

  clk_div_sched #(.CNT_W(4), .DEF_DIV(5), .LOCK_CYC(8)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .hold          (hold),
    .div_req_valid (div_req_valid),
    .div_req_ratio (div_req_ratio),
    .div_req_ready (div_req_ready),
    .en_slow       (en_slow),
    .clk_slow      (clk_slow),
    .locked        (locked),
    .cur_ratio     (cur_ratio),
    .err_bad_ratio (err_bad_ratio)
  );

  always #5 CLK = ~CLK;

  typedef struct {int e; int v;} ev_t;
  ev_t        qs[5][$];
  string      names[5] = '{"en_slow", "err_bad_ratio", "locked", "div_req_ready", "cur_ratio"};
  int         edge_n = 0;
  int         total = 0;
  int         bad = 0;
  bit         exp_clk = 1'b0;
  logic       p_lock, p_rdy;
  logic [3:0] p_ratio;

  always @(posedge CLK) begin
    if (reset) edge_n = 0;
    else edge_n = edge_n + 1;
  end

  task automatic push(input int k, input int e, input int v);
    ev_t x;
    x.e = e;
    x.v = v;
    qs[k].push_back(x);
  endtask

  task automatic push_en(input int start, input int period, input int n);
    for (int i = 0; i < n; i++) begin
      exp_clk = ~exp_clk;
      push(K_EN, start + i * period, int'(exp_clk));
    end
  endtask

  task automatic event_seen(input int k, input int v);
    ev_t x;
    total++;
    if (qs[k].size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event at edge %0d val %0d, none required", names[k], edge_n, v);
    end else begin
      x = qs[k].pop_front();
      if (x.e != edge_n || x.v != v) begin
        bad++;
        $display("FAIL %s: got edge %0d val %0d, want edge %0d val %0d", names[k], edge_n, v, x.e, x.v);
      end
    end
  endtask

  always begin
    @(posedge CLK);
    #1;
    if (!reset) begin
      if (en_slow) event_seen(K_EN, int'(clk_slow));
      if (err_bad_ratio) event_seen(K_ERR, 1);
      if (locked !== p_lock) event_seen(K_LOCK, int'(locked));
      if (div_req_ready !== p_rdy) event_seen(K_RDY, int'(div_req_ready));
      if (cur_ratio !== p_ratio) event_seen(K_RATIO, int'(cur_ratio));
    end
    p_lock  = locked;
    p_rdy   = div_req_ready;
    p_ratio = cur_ratio;
  end

  task automatic go(input int k);
    int g = 0;
    while (edge_n < k - 1) begin
      @(negedge CLK);
      g++;
      if (g > 3000) begin
        total++;
        bad++;
        $display("FAIL wait_edge: got edge %0d, want edge %0d", edge_n, k - 1);
        break;
      end
    end
  endtask

  task automatic req(input int k, input logic [3:0] r);
    go(k);
    div_req_valid = 1'b1;
    div_req_ratio = r;
    go(k + 1);
    div_req_valid = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    logic [8:0] got;
    got = {en_slow, clk_slow, locked, err_bad_ratio, div_req_ready, cur_ratio};
    total++;
    if (got !== 9'b00000_0101) begin
      bad++;
      $display("FAIL %s: got %b, want %b", nm, got, 9'b00000_0101);
    end
  endtask

  task automatic chk_drained(input string nm);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (qs[k].size() != 0) begin
        bad++;
        $display("FAIL %s %s: got %0d pending events, want 0 (next edge %0d)", nm, names[k], qs[k].size(), qs[k][0].e);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset("reset_init");
    reset = 1'b0;

    // ratio 5 lock; bad/no-op requests; switch to 3; switch back to 5 with a hold in LOCK; hold in RUN
    push_en(5, 5, 10);
    push_en(55, 1, 1);
    push_en(59, 3, 8);
    push_en(83, 1, 1);
    push_en(96, 5, 8);
    push_en(138, 1, 1);
    push(K_ERR, 42, 1);
    push(K_ERR, 44, 1);
    push(K_LOCK, 40, 1);  push(K_LOCK, 52, 0);
    push(K_LOCK, 80, 1);  push(K_LOCK, 82, 0);
    push(K_LOCK, 131, 1); push(K_LOCK, 140, 0);
    push(K_RDY, 40, 1);   push(K_RDY, 52, 0);
    push(K_RDY, 80, 1);   push(K_RDY, 82, 0);
    push(K_RDY, 131, 1);  push(K_RDY, 134, 0);
    push(K_RDY, 136, 1);  push(K_RDY, 140, 0);
    push(K_RATIO, 56, 3);
    push(K_RATIO, 84, 5);

    req(42, 4'd1);
    req(44, 4'd0);
    req(47, 4'd5);
    req(52, 4'd3);
    req(82, 4'd5);
    go(87);
    hold = 1'b1;
    go(94);
    hold = 1'b0;
    go(134);
    hold = 1'b1;
    go(136);
    hold = 1'b0;
    req(140, 4'd9);

    go(142);
    chk_drained("before_reset");
    reset = 1'b1;
    #1;
    chk_reset("reset_in_drain");
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    exp_clk = 1'b0;
    push_en(5, 5, 9);
    push(K_LOCK, 40, 1);
    push(K_RDY, 40, 1);
    go(47);
    chk_drained("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
